// File: rtl/associate_trainer.sv
// Training sequencer for an external associate: holds DEPTH samples, runs
// training epochs (forward, result, error, feedback) with early stop, then
// one evaluation pass that reports mismatches and a pass flag.
module associate_trainer #(
  parameter int N      = 2,
  parameter int DEPTH  = 4,
  parameter int EPOCHS = 25
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld_stb,
  output logic                       ld_rdy,
  input  logic [N*8+15:0]            ld_dat,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [$clog2(DEPTH+1)-1:0] errcnt,
  output logic                       en,
  output logic                       arg_stb,
  input  logic                       arg_rdy,
  output logic [N*8-1:0]             arg_dat,
  input  logic                       res_stb,
  output logic                       res_rdy,
  input  logic [15:0]                res_dat,
  output logic                       err_stb,
  input  logic                       err_rdy,
  output logic [15:0]                err_dat,
  input  logic                       fbk_stb,
  output logic                       fbk_rdy,
  input  logic [N*16-1:0]            fbk_dat
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = (EPOCHS > 1) ? $clog2(EPOCHS) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = N * 8 + 16;

  typedef enum logic [2:0] {IDLE, FWD, RES, BWD, FBK, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ldptr_q, ldptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [EW-1:0] epoch_q, epoch_d;
  logic [CW-1:0] eperr_q, eperr_d;
  logic [CW-1:0] errcnt_q, errcnt_d;
  logic          eval_q, eval_d;
  logic          pass_q, pass_d;
  logic [15:0]   err_q, err_d;
  logic [SW-1:0] mem_q [DEPTH];

  logic [SW-1:0] cur;
  logic [15:0]   act;
  logic [15:0]   res_err;
  logic          last;
  logic          ld_xfer;
  logic          fbk_unused;

  // Feedback is accepted only to complete the handshake; its content is dropped.
  assign fbk_unused = ^fbk_dat;

  assign cur     = mem_q[idx_q];
  assign act     = res_dat[15] ? 16'h0000 : 16'h00ff;
  assign res_err = cur[SW-1 -: 16] - act;
  assign last    = (idx_q == IW'(DEPTH - 1));
  // Loads are blocked while rst is high so a reset never disturbs the samples.
  assign ld_xfer = ld_stb && ld_rdy && !rst;

  // Sample memory: written only by load transfers, never cleared.
  always_ff @(posedge clk) begin
    if (ld_xfer) mem_q[ldptr_q] <= ld_dat;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ldptr_q  <= '0;
      idx_q    <= '0;
      epoch_q  <= '0;
      eperr_q  <= '0;
      errcnt_q <= '0;
      eval_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      ldptr_q  <= ldptr_d;
      idx_q    <= idx_d;
      epoch_q  <= epoch_d;
      eperr_q  <= eperr_d;
      errcnt_q <= errcnt_d;
      eval_q   <= eval_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
    end
  end

  // Next-state and counter updates.
  always_comb begin
    state_d  = state_q;
    ldptr_d  = ldptr_q;
    idx_d    = idx_q;
    epoch_d  = epoch_q;
    eperr_d  = eperr_q;
    errcnt_d = errcnt_q;
    eval_d   = eval_q;
    pass_d   = pass_q;
    err_d    = err_q;
    if (ld_xfer) ldptr_d = (ldptr_q == IW'(DEPTH - 1)) ? '0 : ldptr_q + IW'(1);
    unique case (state_q)
      IDLE: if (start) begin
        idx_d    = '0;
        epoch_d  = '0;
        eperr_d  = '0;
        errcnt_d = '0;
        eval_d   = 1'b0;
        state_d  = FWD;
      end
      FWD: if (arg_rdy) state_d = RES;
      RES: if (res_stb) begin
        err_d = res_err;
        if (!eval_q) begin
          if (res_err != '0) eperr_d = eperr_q + CW'(1);
          state_d = BWD;
        end else begin
          if (res_err != '0) errcnt_d = errcnt_q + CW'(1);
          if (last) begin
            pass_d  = (errcnt_d == '0);
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = FWD;
          end
        end
      end
      BWD: if (err_rdy) state_d = FBK;
      FBK: if (fbk_stb) begin
        state_d = FWD;
        if (!last) begin
          idx_d = idx_q + IW'(1);
        end else begin
          idx_d = '0;
          if (epoch_q == EW'(EPOCHS - 1) || eperr_q == '0) begin
            eval_d = 1'b1;
          end else begin
            epoch_d = epoch_q + EW'(1);
            eperr_d = '0;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    ld_rdy  = (state_q == IDLE);
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    arg_stb = (state_q == FWD);
    res_rdy = (state_q == RES);
    err_stb = (state_q == BWD);
    fbk_rdy = (state_q == FBK);
    en      = !eval_q && (state_q inside {FWD, RES, BWD, FBK});
    arg_dat = cur[N*8-1:0];
    err_dat = err_q;
    pass    = pass_q;
    errcnt  = errcnt_q;
  end

endmodule
